// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scanner.
//   state_t    - scanner FSM encodings (BLANK / SHOW)
//   SEG_TABLE  - hex digit to active-low segment pattern {g,f,e,d,c,b,a}
//   SEG_OFF    - all segments dark, including dp
//   DIG_OFF    - no digit enabled
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] DIG_OFF = 4'hF;

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational nibble to seven-segment decode (active-low).
//   i_nib  [3:0] - hex value to display
//   o_seg  [6:0] - segments {g,f,e,d,c,b,a}, 0 = lit
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed seven-segment scanner.
// Shows one 16-bit half of a captured 32-bit word, one digit per slot of
// DIV_MAX clocks, with a single blank cycle at the start of every slot to
// avoid ghosting while the digit enable moves.
//   clk            - sole clock
//   rst            - synchronous active-high reset
//   data_in [31:0] - word to display
//   data_vld       - capture strobe for data_in
//   printhl        - asynchronous half select (1 = bits 31:16)
//   printsig [7:0] - active-low segments {dp,g,f,e,d,c,b,a}, registered
//   segslct  [3:0] - active-low one-hot digit enable, registered
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_BLANK | one cycle after a slot boundary or reset; all outputs off
// ST_SHOW  | digit r_dig enabled with its nibble until the next tick
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIV_MAX     = 50000,
    parameter int SYNC_STAGES = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        data_vld,
    input  logic        printhl,
    output logic [7:0]  printsig,
    output logic [3:0]  segslct
);

    localparam int             PW         = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV_MAX - 1);

    logic [31:0]            r_shadow;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [PW-1:0]          r_presc;
    logic [1:0]             r_dig;
    state_t                 r_state;
    logic [7:0]             r_printsig;
    logic [3:0]             r_segslct;

    state_t                 w_state_nxt;
    logic                   w_tick;
    logic                   w_hl;
    logic [4:0]             w_base;
    logic [3:0]             w_nib;
    logic [6:0]             w_seg7;
    logic [7:0]             w_printsig_nxt;
    logic [3:0]             w_segslct_nxt;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_hl   = r_sync[SYNC_STAGES-1];

    // Bit offset of the nibble: half select adds 16, digit index adds 4n.
    assign w_base = {w_hl, r_dig, 2'b00};
    assign w_nib  = r_shadow[w_base +: 4];

    hex7seg u_hex7seg (
        .i_nib (w_nib),
        .o_seg (w_seg7)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_segslct_nxt  = DIG_OFF;
        w_printsig_nxt = SEG_OFF;

        case (r_state)
            ST_BLANK: w_state_nxt = ST_SHOW;
            ST_SHOW:  if (w_tick) w_state_nxt = ST_BLANK;
            default:  w_state_nxt = ST_BLANK;
        endcase

        // Outputs are decoded for the state being entered so the flops
        // present them in the same cycle the state register does.
        if (w_state_nxt == ST_SHOW) begin
            w_segslct_nxt  = ~(4'b0001 << r_dig);
            w_printsig_nxt = {~(w_hl && (r_dig == 2'd3)), w_seg7};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow   <= '0;
            r_sync     <= '0;
            r_presc    <= '0;
            r_dig      <= '0;
            r_state    <= ST_BLANK;
            r_printsig <= SEG_OFF;
            r_segslct  <= DIG_OFF;
        end else begin
            if (data_vld) r_shadow <= data_in;

            r_sync[0] <= printhl;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end

            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) r_dig <= r_dig + 2'd1;

            r_state    <= w_state_nxt;
            r_printsig <= w_printsig_nxt;
            r_segslct  <= w_segslct_nxt;
        end
    end

    assign printsig = r_printsig;
    assign segslct  = r_segslct;

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;

    localparam int DIV_MAX     = 4;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_vld;
    logic        printhl;
    logic [7:0]  printsig;
    logic [3:0]  segslct;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_scan #(
        .DIV_MAX     (DIV_MAX),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_vld (data_vld),
        .printhl  (printhl),
        .printsig (printsig),
        .segslct  (segslct)
    );

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        hl;
        int          n;
        logic [3:0]  sel;
        logic [7:0]  sig;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic vld, input logic [31:0] data, input logic hl,
                       input int n, input logic [3:0] sel, input logic [7:0] sig);
        vec_t v;
        v.vld = vld; v.data = data; v.hl = hl; v.n = n; v.sel = sel; v.sig = sig;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait for a slot boundary, then for digit d, and check its pattern.
    task automatic check_digit(input int d, input logic [7:0] exp_sig);
        logic [3:0] es;
        int t;
        es = ~(4'b0001 << d);
        t = 0;
        while (segslct !== 4'hF && t < 20) begin cyc(); t++; end
        t = 0;
        while (segslct !== es && t < 20) begin cyc(); t++; end
        check($sformatf("digit%0d sel", d), {4'h0, segslct}, {4'h0, es});
        check($sformatf("digit%0d sig", d), printsig, exp_sig);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n_blank;
        int t;
        logic [3:0] es;
        logic [7:0] xs;

        rst = 1'b1; data_vld = 1'b0; data_in = '0; printhl = 1'b0;
        repeat (3) cyc();
        check("reset sel", {4'h0, segslct}, 8'h0F);
        check("reset sig", printsig, 8'hFF);
        rst = 1'b0;

        // vld  data           hl  n  sel      sig
        add(1, 32'h1234ABCD, 0, 1, 4'b1110, 8'hC0);
        add(0, 32'h0,        0, 2, 4'b1110, 8'hA1);
        add(0, 32'h0,        0, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        0, 3, 4'b1101, 8'hC6);
        add(0, 32'h0,        0, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        0, 3, 4'b1011, 8'h83);
        add(0, 32'h0,        0, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        0, 3, 4'b0111, 8'h88);
        add(0, 32'h0,        0, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        1, 2, 4'b1110, 8'hA1);
        add(0, 32'h0,        1, 1, 4'b1110, 8'h99);
        add(0, 32'h0,        1, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        1, 3, 4'b1101, 8'hB0);
        add(0, 32'h0,        1, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        1, 3, 4'b1011, 8'hA4);
        add(0, 32'h0,        1, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        1, 3, 4'b0111, 8'h79);
        add(0, 32'h0,        1, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        0, 2, 4'b1110, 8'h99);
        add(0, 32'h0,        0, 1, 4'b1110, 8'hA1);
        add(1, 32'hFFFF0000, 0, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        0, 3, 4'b1101, 8'hC0);
        add(0, 32'h0,        1, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        1, 1, 4'b1011, 8'hC0);
        add(0, 32'h0,        1, 2, 4'b1011, 8'h8E);
        add(0, 32'h0,        1, 1, 4'b1111, 8'hFF);
        add(0, 32'h0,        1, 3, 4'b0111, 8'h0E);
        add(0, 32'h0,        1, 1, 4'b1111, 8'hFF);

        foreach (tbl[r]) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                data_vld = (c == 0) && tbl[r].vld;
                data_in  = tbl[r].data;
                printhl  = tbl[r].hl;
                cyc();
                check($sformatf("vec%0d.%0d sel", r, c), {4'h0, segslct}, {4'h0, tbl[r].sel});
                check($sformatf("vec%0d.%0d sig", r, c), printsig, tbl[r].sig);
            end
        end
        data_vld = 1'b0;

        // 20 slots of wrap-around: shadow FFFF0000 with the high half shown.
        n_blank = 0;
        for (int k = 1; k <= 80; k++) begin
            cyc();
            if (k % 4 == 0) begin
                es = 4'hF;
                xs = 8'hFF;
            end else begin
                es = ~(4'b0001 << ((k / 4) % 4));
                xs = (((k / 4) % 4) == 3) ? 8'h0E : 8'h8E;
            end
            if (segslct === 4'hF) n_blank++;
            check($sformatf("wrap%0d sel", k), {4'h0, segslct}, {4'h0, es});
            check($sformatf("wrap%0d sig", k), printsig, xs);
        end
        check("wrap blank count", 8'(n_blank), 8'd20);

        // Reset in the middle of digit 2's slot.
        t = 0;
        while (segslct !== 4'b1011 && t < 20) begin cyc(); t++; end
        check("reach digit2 sel", {4'h0, segslct}, 8'h0B);
        cyc();
        rst = 1'b1;
        cyc();
        check("midrst sel", {4'h0, segslct}, 8'h0F);
        check("midrst sig", printsig, 8'hFF);
        cyc();
        rst = 1'b0;
        printhl = 1'b0;
        check("midrst release sel", {4'h0, segslct}, 8'h0F);
        cyc();
        check("restart d0 sel", {4'h0, segslct}, 8'h0E);
        check("restart d0 sig", printsig, 8'hC0);
        repeat (3) cyc();
        check("restart blank sel", {4'h0, segslct}, 8'h0F);
        cyc();
        check("restart d1 sel", {4'h0, segslct}, 8'h0D);
        check("restart d1 sig", printsig, 8'hC0);

        // Remaining table entries.
        data_vld = 1'b1; data_in = 32'h00009876;
        cyc();
        data_vld = 1'b0;
        check_digit(0, 8'h82);
        check_digit(1, 8'hF8);
        check_digit(2, 8'h80);
        check_digit(3, 8'h90);
        data_vld = 1'b1; data_in = 32'h00005E00;
        cyc();
        data_vld = 1'b0;
        check_digit(2, 8'h86);
        check_digit(3, 8'h92);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
